// File: rtl/serial_subtractor8.sv
// Bit-serial two's-complement subtractor, D = A - B, LSB first.
// One full-adder cell fed ~B with its carry preset to 1.
module serial_subtractor8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_bout;
  logic             r_v;

  logic w_acc;
  logic w_last;
  logic w_nb;
  logic w_s;
  logic w_cn;

  assign w_acc  = (r_state == S_IDLE) && start;
  assign w_last = (r_state == S_RUN) &&
                  (r_cnt == CW'(WIDTH - 1));
  assign w_nb   = ~r_b[0];
  assign w_s    = r_a[0] ^ w_nb ^ r_c;
  assign w_cn   = (r_a[0] & w_nb) |
                  (r_c & (r_a[0] ^ w_nb));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_IDLE:  busy = 1'b0;
      S_RUN:   busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_bout <= 1'b0;
      r_v    <= 1'b0;
    end else if (w_acc) begin
      r_a    <= A;
      r_b    <= B;
      r_d    <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b1;
      r_bout <= 1'b0;
      r_v    <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_d   <= {w_s, r_d[WIDTH-1:1]};
      r_c   <= w_cn;
      r_cnt <= r_cnt + CW'(1);
      // r_c here is the carry into the MSB cell
      if (w_last) begin
        r_bout <= ~w_cn;
        r_v    <= r_c ^ w_cn;
      end
    end
  end

  assign D    = r_d;
  assign Bout = r_bout;
  assign V    = r_v;

endmodule

// File: tb/tb_serial_subtractor8.sv
// Self-checking bench for serial_subtractor8 (WIDTH 8 and 16).
// Directed steps then random sweeps against an arithmetic model.
module tb_serial_subtractor8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, d8;
  logic        busy8, done8, bo8, v8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, d16;
  logic        busy16, done16, bo16, v16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_subtractor8 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .A(a8), .B(b8), .busy(busy8), .done(done8),
    .D(d8), .Bout(bo8), .V(v8)
  );

  serial_subtractor8 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16),
    .A(a16), .B(b16), .busy(busy16), .done(done16),
    .D(d16), .Bout(bo16), .V(v16)
  );

  task automatic chk(input string tag,
                     input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // returns {V, Bout, D}
  function automatic longint ref_sub(input longint a,
                                     input longint b,
                                     input int w);
    longint m, d, sa, sb, df;
    longint bo, v;
    m  = (longint'(1) << w) - 1;
    d  = (a - b) & m;
    bo = (a < b) ? 1 : 0;
    sa = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
    sb = (b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
    df = sa - sb;
    v  = (df > (longint'(1) << (w - 1)) - 1 ||
          df < -(longint'(1) << (w - 1))) ? 1 : 0;
    return (v << (w + 1)) | (bo << w) | d;
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int n;
    longint r;
    r = ref_sub(a, b, 8);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    chk("busy8_run", busy8, 1);
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("lat8", n, 8);
    chk("d8", d8, r & 'hFF);
    chk("bout8", bo8, (r >> 8) & 1);
    chk("v8", v8, (r >> 9) & 1);
    @(negedge clk);
    chk("done8_pulse", done8, 0);
    chk("busy8_idle", busy8, 0);
    chk("d8_hold", d8, r & 'hFF);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b);
    int n;
    longint r;
    r = ref_sub(a, b, 16);
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b;
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    n = 0;
    while (done16 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("lat16", n, 16);
    chk("d16", d16, r & 'hFFFF);
    chk("bout16", bo16, (r >> 16) & 1);
    chk("v16", v16, (r >> 17) & 1);
  endtask

  initial begin
    int nbusy, ndone;
    logic [7:0] ra, rb;
    logic [15:0] qa, qb;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_d", d8, 0);
    chk("rst_bout", bo8, 0);
    chk("rst_v", v8, 0);
    chk("rst_d16", d16, 0);
    rst = 1'b0;

    // directed vectors
    op8(8'h5A, 8'h23);
    op8(8'h00, 8'h01);
    op8(8'h80, 8'h01);
    op8(8'h7F, 8'hFF);
    op8(8'hC3, 8'hC3);
    op8(8'h7F, 8'h80);
    op8(8'hFF, 8'h00);
    op8(8'h00, 8'h00);

    // second start while busy is ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy8) nbusy++;
      if (done8) ndone++;
      if (i == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end
      if (i == 3) start8 = 1'b0;
      @(negedge clk);
    end
    chk("ign_busy_cycles", nbusy, 9);
    chk("ign_done_pulses", ndone, 1);
    chk("ign_d", d8, 8'h0F);

    // reset mid-run aborts
    op8(8'h33, 8'h11);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h9C; b8 = 8'h21;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_d", d8, 0);
    chk("abort_bout", bo8, 0);
    chk("abort_v", v8, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    op8(8'h05, 8'h03);

    // rst wins over start
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    chk("rst_wins_busy", busy8, 0);

    // random sweeps
    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8(ra, rb);
    end
    op16(16'h0000, 16'h0001);
    op16(16'h8000, 16'h0001);
    op16(16'h7FFF, 16'hFFFF);
    for (int i = 0; i < 400; i++) begin
      qa = 16'($urandom); qb = 16'($urandom);
      op16(qa, qb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
